apple_trap_sequencer: RTL and testbench

- Sequences a group of falling-apple traps for one screen.
- Waits for the kid to cross a trigger column, then releases apples one at a time at a fixed tick spacing.
- Drives the shared two-frame sprite animation bit and tracks completion.
- Freezes the group on the first kid collision with a released apple.
- Sits between the kid/position logic and the per-apple instances; each apple's trigger input is driven from release[k].

---
 rtl/apple_pkg.sv | 18 +
 rtl/apple_prio_enc.sv | 20 ++
 rtl/apple_trap_sequencer.sv | 161 ++++++++++++++++
 tb/tb_apple_trap_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/apple_pkg.sv
// Shared types and sizes for the apple trap group: sequencer state encoding
// and the widths the sequencer and its priority encoder agree on.
package apple_pkg;

  localparam int MAX_APPLES  = 8;
  localparam int APPLE_IDX_W = 3;
  localparam int GAP_W       = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RELEASE  = 3'd1,
    ST_WAIT_GAP = 3'd2,
    ST_FALLING  = 3'd3,
    ST_DONE     = 3'd4,
    ST_HIT      = 3'd5
  } apple_state_e;

endpackage

// File: rtl/apple_prio_enc.sv
// Lowest-set-bit priority encoder over the full apple slot width; picks the
// lowest-numbered apple when several collide on the same tick.
module apple_prio_enc
  import apple_pkg::*;
(
  input  logic [MAX_APPLES-1:0]  req_i,
  output logic [APPLE_IDX_W-1:0] idx_o,
  output logic                   valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = |req_i;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = MAX_APPLES - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = APPLE_IDX_W'(i);
    end
  end

endmodule

// File: rtl/apple_trap_sequencer.sv
// Falling-apple trap group sequencer: waits for the kid to cross a column,
// releases apples at a fixed spacing, drives the shared sprite frame bit,
// and freezes the whole group on the first collision.
module apple_trap_sequencer
  import apple_pkg::*;
#(
  parameter int NUM_APPLES = 4,
  parameter int TRIG_X     = 0,
  parameter int GAP        = 2
) (
  input  logic                   toggle_clk,
  input  logic                   rst,
  input  logic                   enable_i,
  input  logic [9:0]             kid_x_i,
  input  logic [9:0]             kid_y_i,
  input  logic [NUM_APPLES-1:0]  apple_collide_i,
  input  logic [NUM_APPLES-1:0]  apple_gone_i,
  output logic [NUM_APPLES-1:0]  release_o,
  output logic                   frame_o,
  output logic                   busy_o,
  output logic                   all_gone_o,
  output logic                   kid_hit_o,
  output logic [APPLE_IDX_W-1:0] hit_index_o,
  output logic [9:0]             trig_y_o,
  output apple_state_e           state_o
);

  localparam logic [9:0]             TRIG_X_L = 10'(TRIG_X);
  localparam logic [APPLE_IDX_W-1:0] LAST_IDX = APPLE_IDX_W'(NUM_APPLES - 1);
  localparam logic [GAP_W-1:0]       GAP_INIT = GAP_W'(GAP - 1);

  apple_state_e           state_q;
  logic [APPLE_IDX_W-1:0] idx_q;
  logic [GAP_W-1:0]       gap_cnt_q;
  logic [NUM_APPLES-1:0]  release_q;
  logic                   frame_q;
  logic                   busy_q;
  logic                   all_gone_q;
  logic                   kid_hit_q;
  logic [APPLE_IDX_W-1:0] hit_index_q;
  logic [9:0]             trig_y_q;

  logic [MAX_APPLES-1:0]  hit_vec;
  logic [APPLE_IDX_W-1:0] enc_idx;
  logic                   hit;
  logic [NUM_APPLES-1:0]  release_d;

  // Only apples already released can hurt the kid.
  assign hit_vec   = MAX_APPLES'(apple_collide_i & release_q);
  assign release_d = release_q | (NUM_APPLES'(1) << idx_q);

  apple_prio_enc u_prio_enc (
    .req_i   (hit_vec),
    .idx_o   (enc_idx),
    .valid_o (hit)
  );

  always_ff @(posedge toggle_clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      gap_cnt_q   <= '0;
      release_q   <= '0;
      frame_q     <= 1'b0;
      busy_q      <= 1'b0;
      all_gone_q  <= 1'b0;
      kid_hit_q   <= 1'b0;
      hit_index_q <= '0;
      trig_y_q    <= '0;
    end else if (enable_i) begin
      kid_hit_q <= 1'b0;
      if (state_q != ST_HIT) frame_q <= ~frame_q;

      case (state_q)
        ST_IDLE: begin
          if (kid_x_i >= TRIG_X_L) begin
            state_q  <= ST_RELEASE;
            idx_q    <= '0;
            trig_y_q <= kid_y_i;
            busy_q   <= 1'b1;
          end
        end

        ST_RELEASE: begin
          if (hit) begin
            state_q     <= ST_HIT;
            kid_hit_q   <= 1'b1;
            hit_index_q <= enc_idx;
            busy_q      <= 1'b0;
          end else begin
            release_q <= release_d;
            if (idx_q == LAST_IDX) begin
              state_q <= ST_FALLING;
            end else if (GAP == 0) begin
              idx_q <= idx_q + 1'b1;
            end else begin
              state_q   <= ST_WAIT_GAP;
              gap_cnt_q <= GAP_INIT;
            end
          end
        end

        ST_WAIT_GAP: begin
          if (hit) begin
            state_q     <= ST_HIT;
            kid_hit_q   <= 1'b1;
            hit_index_q <= enc_idx;
            busy_q      <= 1'b0;
          end else if (gap_cnt_q == '0) begin
            state_q <= ST_RELEASE;
            idx_q   <= idx_q + 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end

        ST_FALLING: begin
          if (hit) begin
            state_q     <= ST_HIT;
            kid_hit_q   <= 1'b1;
            hit_index_q <= enc_idx;
            busy_q      <= 1'b0;
          end else if ((apple_gone_i & release_q) == release_q) begin
            state_q    <= ST_DONE;
            all_gone_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end

        ST_DONE: begin
          // An apple can still be on screen at the kid's position after
          // it counted as gone elsewhere; the group freezes the same way.
          if (hit) begin
            state_q     <= ST_HIT;
            kid_hit_q   <= 1'b1;
            hit_index_q <= enc_idx;
          end
        end

        ST_HIT: begin
          state_q <= ST_HIT;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign release_o   = release_q;
  assign frame_o     = frame_q;
  assign busy_o      = busy_q;
  assign all_gone_o  = all_gone_q;
  assign kid_hit_o   = kid_hit_q;
  assign hit_index_o = hit_index_q;
  assign trig_y_o    = trig_y_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_apple_trap_sequencer.sv
// Directed bench for apple_trap_sequencer: one instance with GAP=2 and one
// with GAP=0, both triggering at kid_x >= 100, driven from shared inputs.
module tb_apple_trap_sequencer;
  import apple_pkg::*;

  localparam int N = 4;

  logic         toggle_clk;
  logic         rst;
  logic         enable;
  logic [9:0]   kid_x;
  logic [9:0]   kid_y;
  logic [N-1:0] apple_collide;
  logic [N-1:0] apple_gone;

  logic [N-1:0] release_a, release_b;
  logic         frame_a, frame_b;
  logic         busy_a, busy_b;
  logic         all_gone_a, all_gone_b;
  logic         kid_hit_a, kid_hit_b;
  logic [2:0]   hit_index_a, hit_index_b;
  logic [9:0]   trig_y_a, trig_y_b;
  apple_state_e state_a, state_b;

  int checks = 0;
  int errors = 0;

  // Clock and reset
  initial toggle_clk = 1'b0;
  always #5 toggle_clk = ~toggle_clk;

  apple_trap_sequencer #(.NUM_APPLES(N), .TRIG_X(100), .GAP(2)) dut (
    .toggle_clk      (toggle_clk),
    .rst             (rst),
    .enable_i        (enable),
    .kid_x_i         (kid_x),
    .kid_y_i         (kid_y),
    .apple_collide_i (apple_collide),
    .apple_gone_i    (apple_gone),
    .release_o       (release_a),
    .frame_o         (frame_a),
    .busy_o          (busy_a),
    .all_gone_o      (all_gone_a),
    .kid_hit_o       (kid_hit_a),
    .hit_index_o     (hit_index_a),
    .trig_y_o        (trig_y_a),
    .state_o         (state_a)
  );

  apple_trap_sequencer #(.NUM_APPLES(N), .TRIG_X(100), .GAP(0)) dut_gap0 (
    .toggle_clk      (toggle_clk),
    .rst             (rst),
    .enable_i        (enable),
    .kid_x_i         (kid_x),
    .kid_y_i         (kid_y),
    .apple_collide_i (apple_collide),
    .apple_gone_i    (apple_gone),
    .release_o       (release_b),
    .frame_o         (frame_b),
    .busy_o          (busy_b),
    .all_gone_o      (all_gone_b),
    .kid_hit_o       (kid_hit_b),
    .hit_index_o     (hit_index_b),
    .trig_y_o        (trig_y_b),
    .state_o         (state_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks: advance one edge, then settle away from it
  task automatic step();
    @(posedge toggle_clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apple_collide = '0;
    apple_gone = '0;
    kid_x = 10'd0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b1;
    kid_x = 10'd0;
    kid_y = 10'd0;
    apple_collide = '0;
    apple_gone = '0;
    #2;

    // Reset values
    do_reset();
    check_eq("rst_release", 32'(release_a), 32'h0);
    check_eq("rst_frame", 32'(frame_a), 32'h0);
    check_eq("rst_busy", 32'(busy_a), 32'h0);
    check_eq("rst_state", 32'(state_a), 32'(ST_IDLE));
    check_eq("rst_all_gone", 32'(all_gone_a), 32'h0);
    check_eq("rst_kid_hit", 32'(kid_hit_a), 32'h0);
    check_eq("rst_hit_index", 32'(hit_index_a), 32'h0);
    check_eq("rst_trig_y", 32'(trig_y_a), 32'h0);

    // kid_x just below threshold, then at threshold (T0)
    kid_x = 10'd99; kid_y = 10'd321;
    step();
    check_eq("below_thresh_state", 32'(state_a), 32'(ST_IDLE));
    kid_x = 10'd100;
    step();                                   // T0
    kid_y = 10'd5;
    check_eq("t0_state", 32'(state_a), 32'(ST_RELEASE));
    check_eq("t0_trig_y", 32'(trig_y_a), 32'd321);
    check_eq("t0_release", 32'(release_a), 32'h0);
    step();                                   // T0+1
    check_eq("t1_release", 32'(release_a), 32'h1);
    check_eq("t1_busy", 32'(busy_a), 32'h1);
    check_eq("g0_t1_release", 32'(release_b), 32'h1);
    check_eq("trig_y_held", 32'(trig_y_a), 32'd321);
    step();                                   // T0+2
    check_eq("g0_t2_release", 32'(release_b), 32'h3);
    step();                                   // T0+3
    check_eq("t3_release", 32'(release_a), 32'h1);
    check_eq("g0_t3_release", 32'(release_b), 32'h7);
    step();                                   // T0+4
    check_eq("t4_release", 32'(release_a), 32'h3);
    check_eq("g0_t4_release", 32'(release_b), 32'hF);
    check_eq("g0_t4_state", 32'(state_b), 32'(ST_FALLING));
    steps(2);                                 // T0+6
    check_eq("t6_release", 32'(release_a), 32'h3);
    step();                                   // T0+7
    check_eq("t7_release", 32'(release_a), 32'h7);
    check_eq("t7_frame", 32'(frame_a), 32'h1);
    steps(3);                                 // T0+10
    check_eq("t10_release", 32'(release_a), 32'hF);
    check_eq("t10_state", 32'(state_a), 32'(ST_FALLING));
    check_eq("t10_frame", 32'(frame_a), 32'h0);

    // Completion
    apple_gone = 4'b0111;
    step();
    check_eq("partial_gone_all_gone", 32'(all_gone_a), 32'h0);
    check_eq("partial_gone_state", 32'(state_a), 32'(ST_FALLING));
    apple_gone = 4'b1111;
    step();
    check_eq("all_gone", 32'(all_gone_a), 32'h1);
    check_eq("done_state", 32'(state_a), 32'(ST_DONE));
    check_eq("done_busy", 32'(busy_a), 32'h0);
    step();
    check_eq("done_hold_all_gone", 32'(all_gone_a), 32'h1);

    // Collision: unreleased apple ignored, released apple freezes group
    do_reset();
    kid_x = 10'd100;
    step();                                   // T0
    steps(4);                                 // T0+4
    check_eq("c_t4_release", 32'(release_a), 32'h3);
    apple_collide = 4'b0100;
    step();                                   // T0+5
    check_eq("c_unreleased_kid_hit", 32'(kid_hit_a), 32'h0);
    check_eq("c_unreleased_state", 32'(state_a), 32'(ST_WAIT_GAP));
    apple_collide = 4'b0010;
    step();                                   // T0+6
    check_eq("c_kid_hit", 32'(kid_hit_a), 32'h1);
    check_eq("c_hit_index", 32'(hit_index_a), 32'h1);
    check_eq("c_state", 32'(state_a), 32'(ST_HIT));
    check_eq("c_frame", 32'(frame_a), 32'h1);
    step();                                   // T0+7
    check_eq("c_kid_hit_pulse", 32'(kid_hit_a), 32'h0);
    check_eq("c_release_frozen", 32'(release_a), 32'h3);
    check_eq("c_frame_frozen", 32'(frame_a), 32'h1);
    check_eq("c_busy", 32'(busy_a), 32'h0);
    apple_collide = 4'b0011;
    steps(2);
    check_eq("c_no_second_hit", 32'(kid_hit_a), 32'h0);
    check_eq("c_hit_index_frozen", 32'(hit_index_a), 32'h1);

    // Pause during WAIT_GAP, then reset mid-sequence
    do_reset();
    kid_x = 10'd100;
    step();                                   // T0
    step();                                   // T0+1
    check_eq("p_t1_release", 32'(release_a), 32'h1);
    check_eq("p_t1_frame", 32'(frame_a), 32'h0);
    enable = 1'b0;
    steps(3);
    check_eq("p_paused_release", 32'(release_a), 32'h1);
    check_eq("p_paused_frame", 32'(frame_a), 32'h0);
    check_eq("p_paused_state", 32'(state_a), 32'(ST_WAIT_GAP));
    enable = 1'b1;
    steps(2);
    check_eq("p_shift_release_early", 32'(release_a), 32'h1);
    step();
    check_eq("p_shift_release", 32'(release_a), 32'h3);
    check_eq("p_shift_frame", 32'(frame_a), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("p_rst_release", 32'(release_a), 32'h0);
    check_eq("p_rst_frame", 32'(frame_a), 32'h0);
    check_eq("p_rst_state", 32'(state_a), 32'(ST_IDLE));
    step();
    check_eq("p_retrigger_state", 32'(state_a), 32'(ST_RELEASE));

    // Multi-apple hit on a release edge
    do_reset();
    kid_x = 10'd100;
    step();                                   // T0
    steps(6);                                 // T0+6
    check_eq("m_t6_state", 32'(state_a), 32'(ST_RELEASE));
    apple_collide = 4'b0011;
    step();                                   // T0+7
    check_eq("m_kid_hit", 32'(kid_hit_a), 32'h1);
    check_eq("m_hit_index", 32'(hit_index_a), 32'h0);
    check_eq("m_release_blocked", 32'(release_a), 32'h3);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
